// File: rtl/instruction_issue_pkg.sv
// Shared types for the instruction issue stage: execution pipe selector
// (one-hot, so it can be ANDed directly against per-pipe ready bits) and
// the decoded-instruction record passed from ID through issue.
package instruction_issue_pkg;

  typedef enum logic [3:0] {
    EXE_PIPE_INVALID = 4'b0000,
    EXE_PIPE_ALU     = 4'b0001,
    EXE_PIPE_MUL     = 4'b0010,
    EXE_PIPE_DIV     = 4'b0100,
    EXE_PIPE_LSU     = 4'b1000
  } exe_pipe_e;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] rd;
    exe_pipe_e  exe_pipe;
    logic       register_write;
    logic [7:0] controls;
  } id_ix_inf_t;

endpackage

// File: rtl/instruction_issue.sv
// In-order issue stage: a small instruction queue, a 32x32 register file and
// a pending-write scoreboard. The queue head dispatches when its pipe is
// ready and it has no RAW/WAW hazard; a same-cycle writeback counts as
// resolving the hazard and supplies the operand directly.
//
// Handshake: ix_valid is a one-cycle pulse per dispatched instruction with
// no back-pressure; the consumer must take it. Flow control towards the
// queue is done only through exe_ready (per pipe, sampled combinationally
// against the head) and ix_almost_full (registered, towards fetch).
module instruction_issue
  import instruction_issue_pkg::*;
#(
  parameter int IQ_DEPTH = 4,
  parameter int AF_SLACK = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_do_branch,
  input  logic                          id_valid,
  input  id_ix_inf_t                    id_ix_inf,
  input  logic                          wb_valid,
  input  logic [4:0]                    wb_rd,
  input  logic [31:0]                   wb_result,
  input  logic [$bits(exe_pipe_e)-1:0]  exe_ready,
  output logic                          ix_valid,
  output id_ix_inf_t                    ix_inf,
  output logic [31:0]                   ix_a1_data,
  output logic [31:0]                   ix_a2_data,
  output logic                          ix_almost_full
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(IQ_DEPTH);
  localparam logic [PW:0] AF_LEVEL   = (PW+1)'(IQ_DEPTH - AF_SLACK);

  if (IQ_DEPTH < 4 || (IQ_DEPTH & (IQ_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instruction_issue: IQ_DEPTH must be a power of two and >= 4");
  end

  id_ix_inf_t    iq_q [IQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   sb_q, sb_d;
  logic [31:0]   rf_q [32];
  logic          ix_valid_q, ix_valid_d;
  id_ix_inf_t    ix_inf_q;
  logic [31:0]   ix_a1_q, ix_a2_q;

  id_ix_inf_t    head;
  logic          head_valid, head_invalid, full;
  logic          push_req, push, issue, drop, pop;
  logic          a1_pend, a2_pend, rd_pend;
  logic [31:0]   a1_data, a2_data;

  // Head inspection: hazard checks with writeback bypass, issue/drop/push decisions.
  always_comb begin
    head         = iq_q[rd_ptr_q];
    head_valid   = (count_q != '0);
    head_invalid = (head.exe_pipe == EXE_PIPE_INVALID);
    full         = (count_q == FULL_LEVEL);
    a1_pend      = sb_q[head.a1] && !(wb_valid && wb_rd == head.a1);
    a2_pend      = sb_q[head.a2] && !(wb_valid && wb_rd == head.a2);
    rd_pend      = sb_q[head.rd] && !(wb_valid && wb_rd == head.rd);
    issue        = head_valid && !wb_do_branch && !head_invalid &&
                   ((exe_ready & head.exe_pipe) != '0) &&
                   !a1_pend && !a2_pend && !(head.register_write && rd_pend);
    drop         = head_valid && !wb_do_branch && head_invalid;
    pop          = issue || drop;
    push_req     = id_valid && !wb_do_branch;
    push         = push_req && (!full || pop);
  end

  // Operand read: x0 is hard zero, a same-cycle writeback overrides the array.
  always_comb begin
    a1_data = rf_q[head.a1];
    a2_data = rf_q[head.a2];
    if (wb_valid && wb_rd == head.a1) a1_data = wb_result;
    if (wb_valid && wb_rd == head.a2) a2_data = wb_result;
    if (head.a1 == 5'd0) a1_data = '0;
    if (head.a2 == 5'd0) a2_data = '0;
  end

  // Next-state for pointers, occupancy and scoreboard; a flush clears all of it.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    sb_d       = sb_q;
    ix_valid_d = issue;
    count_d    = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    // Clear before set so an issuing writer of the same rd keeps the bit.
    if (wb_valid) sb_d[wb_rd] = 1'b0;
    if (issue && head.register_write) sb_d[head.rd] = 1'b1;
    if (wb_do_branch) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      sb_d     = '0;
    end
    sb_d[0] = 1'b0;
  end

  // Control state register with synchronous reset; flags a dropped push.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      sb_q       <= '0;
      ix_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      sb_q       <= sb_d;
      ix_valid_q <= ix_valid_d;
      assert (!(push_req && full && !pop))
        else $warning("instruction_issue: queue full, incoming entry dropped");
    end
  end

  // Queue storage write; contents need no reset since occupancy gates use.
  always_ff @(posedge clk) begin
    if (push) iq_q[wr_ptr_q] <= id_ix_inf;
  end

  // Register file write; x0 is never written and a flush does not block it.
  always_ff @(posedge clk) begin
    if (wb_valid && wb_rd != 5'd0) rf_q[wb_rd] <= wb_result;
  end

  // Dispatch payload capture, qualified by ix_valid downstream.
  always_ff @(posedge clk) begin
    if (issue) begin
      ix_inf_q <= head;
      ix_a1_q  <= a1_data;
      ix_a2_q  <= a2_data;
    end
  end

  assign ix_valid       = ix_valid_q;
  assign ix_inf         = ix_inf_q;
  assign ix_a1_data     = ix_a1_q;
  assign ix_a2_data     = ix_a2_q;
  assign ix_almost_full = (count_q >= AF_LEVEL);

endmodule

// File: tb/tb_instruction_issue.sv
// Directed bench for instruction_issue: expected dispatches are queued as
// stimulus is driven and matched in order by a dispatch monitor.
module tb_instruction_issue;
  import instruction_issue_pkg::*;

  localparam int DW = $bits(id_ix_inf_t) + 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_do_branch;
  logic        id_valid;
  id_ix_inf_t  id_ix_inf;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [3:0]  exe_ready;
  logic        ix_valid;
  id_ix_inf_t  ix_inf;
  logic [31:0] ix_a1_data;
  logic [31:0] ix_a2_data;
  logic        ix_almost_full;

  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  instruction_issue #(.IQ_DEPTH(4), .AF_SLACK(2)) dut (
    .clk(clk), .rst(rst), .wb_do_branch(wb_do_branch),
    .id_valid(id_valid), .id_ix_inf(id_ix_inf),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
    .exe_ready(exe_ready), .ix_valid(ix_valid), .ix_inf(ix_inf),
    .ix_a1_data(ix_a1_data), .ix_a2_data(ix_a2_data),
    .ix_almost_full(ix_almost_full)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic id_ix_inf_t mk(input logic [4:0] a1, input logic [4:0] a2,
                                    input logic [4:0] rd, input exe_pipe_e p,
                                    input logic rw, input logic [7:0] ctl);
    id_ix_inf_t r;
    r.a1 = a1; r.a2 = a2; r.rd = rd; r.exe_pipe = p;
    r.register_write = rw; r.controls = ctl;
    return r;
  endfunction

  task automatic drive_id(input id_ix_inf_t inf);
    id_valid  = 1'b1;
    id_ix_inf = inf;
  endtask

  task automatic exp_push(input id_ix_inf_t inf, input logic [31:0] d1, input logic [31:0] d2);
    exp_q.push_back({inf, d1, d2});
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Dispatch monitor: every ix_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ix_valid) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL dispatch_unexpected: observed inf=%0h expected none", ix_inf);
      end
      if (exp_q.size() != 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        assert ({ix_inf, ix_a1_data, ix_a2_data} === e) else begin
          bad++;
          $error("FAIL dispatch: observed=%0h expected=%0h", {ix_inf, ix_a1_data, ix_a2_data}, e);
        end
      end
    end
  end

  id_ix_inf_t i1, i2, i3, i7, m_op, a_op, iv, ov6;
  id_ix_inf_t ops[3];
  id_ix_inf_t ovf[4];

  initial begin
    rst = 1'b1; wb_do_branch = 1'b0; id_valid = 1'b0; id_ix_inf = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_result = '0; exe_ready = 4'hF;
    tick(); tick();
    chk("rst_ix_valid", ix_valid, 0);
    chk("rst_almost_full", ix_almost_full, 0);
    chk("rst_count", dut.count_q, 0);
    chk("rst_sb", dut.sb_q, 0);
    rst = 1'b0;

    // Preload x2 = 0x55.
    wb_valid = 1'b1; wb_rd = 5'd2; wb_result = 32'h55;
    tick();
    wb_valid = 1'b0;

    // addi x1: dispatch pulse after the second edge, x1 marked pending.
    i1 = mk(5'd0, 5'd0, 5'd1, EXE_PIPE_ALU, 1'b1, 8'h01);
    drive_id(i1); exp_push(i1, 32'h0, 32'h0);
    tick();
    id_valid = 1'b0;
    chk("t1_not_early", ix_valid, 0);
    tick();
    chk("t1_valid", ix_valid, 1);
    chk("t1_sb1", dut.sb_q[1], 1);
    tick();
    chk("t1_one_pulse", ix_valid, 0);

    // add x3,x1,x2 waits on x1; WB of x1 bypasses into the dispatch.
    i2 = mk(5'd1, 5'd2, 5'd3, EXE_PIPE_ALU, 1'b1, 8'h02);
    drive_id(i2);
    tick();
    id_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("t2_raw_stall", ix_valid, 0);
    end
    chk("t2_count", dut.count_q, 1);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_result = 32'h1234;
    exp_push(i2, 32'h1234, 32'h55);
    tick();
    wb_valid = 1'b0;
    chk("t2_valid", ix_valid, 1);
    chk("t2_a1_bypass", ix_a1_data, 32'h1234);
    chk("t2_sb3", dut.sb_q[3], 1);
    chk("t2_sb1_cleared", dut.sb_q[1], 0);
    tick();

    // WAW on x3 resolved by same-cycle WB: issue sets the bit again.
    i3 = mk(5'd0, 5'd0, 5'd3, EXE_PIPE_ALU, 1'b1, 8'h03);
    drive_id(i3);
    tick();
    id_valid = 1'b0;
    tick();
    chk("t3_waw_stall", ix_valid, 0);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_result = 32'hAAAA;
    exp_push(i3, 32'h0, 32'h0);
    tick();
    chk("t3_valid", ix_valid, 1);
    chk("t3_set_wins", dut.sb_q[3], 1);
    wb_result = 32'hBBBB;
    tick();
    wb_valid = 1'b0;
    chk("t3_sb3_clear", dut.sb_q[3], 0);

    // Back-to-back independent ops dispatch one per cycle.
    for (int k = 0; k < 3; k++)
      ops[k] = mk(5'd2, 5'd0, 5'(4 + k), EXE_PIPE_ALU, 1'b1, 8'(8'h04 + k));
    for (int k = 0; k < 3; k++) begin
      drive_id(ops[k]); exp_push(ops[k], 32'h55, 32'h0);
      tick();
      if (k > 0) chk("t4_throughput", ix_valid, 1);
    end
    id_valid = 1'b0;
    tick();
    chk("t4_throughput_last", ix_valid, 1);
    tick();
    chk("t4_idle", ix_valid, 0);

    // Flush with three queued and x5 pending; the WB write still lands.
    exe_ready = 4'h0;
    for (int k = 0; k < 3; k++) begin
      drive_id(mk(5'd0, 5'd0, 5'(7 + k), EXE_PIPE_ALU, 1'b1, 8'(8'h10 + k)));
      tick();
    end
    id_valid = 1'b0;
    chk("t5_count3", dut.count_q, 3);
    chk("t5_almost_full", ix_almost_full, 1);
    chk("t5_sb5", dut.sb_q[5], 1);
    wb_do_branch = 1'b1; wb_valid = 1'b1; wb_rd = 5'd10; wb_result = 32'hCAFE;
    exe_ready = 4'hF;
    drive_id(mk(5'd0, 5'd0, 5'd0, EXE_PIPE_ALU, 1'b0, 8'hEE));
    tick();
    wb_do_branch = 1'b0; wb_valid = 1'b0; id_valid = 1'b0;
    chk("t5_count0", dut.count_q, 0);
    chk("t5_sb0", dut.sb_q, 0);
    chk("t5_no_dispatch", ix_valid, 0);
    chk("t5_af_low", ix_almost_full, 0);
    i7 = mk(5'd10, 5'd0, 5'd0, EXE_PIPE_ALU, 1'b0, 8'h20);
    drive_id(i7); exp_push(i7, 32'hCAFE, 32'h0);
    tick();
    id_valid = 1'b0;
    tick();
    chk("t5_wb_landed", ix_a1_data, 32'hCAFE);

    // MUL head not ready blocks the ready ALU op behind it.
    exe_ready = 4'b0001;
    m_op = mk(5'd2, 5'd0, 5'd11, EXE_PIPE_MUL, 1'b1, 8'h30);
    a_op = mk(5'd0, 5'd0, 5'd12, EXE_PIPE_ALU, 1'b1, 8'h31);
    drive_id(m_op);
    tick();
    drive_id(a_op);
    tick();
    id_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_in_order_stall", ix_valid, 0);
    end
    chk("t6_count2", dut.count_q, 2);
    exe_ready = 4'b0011;
    exp_push(m_op, 32'h55, 32'h0);
    exp_push(a_op, 32'h0, 32'h0);
    tick();
    chk("t6_mul_issue", ix_valid, 1);
    tick();
    chk("t6_alu_issue", ix_valid, 1);
    tick();
    chk("t6_idle", ix_valid, 0);

    // INVALID pipe entry is discarded in one cycle without dispatch.
    iv = mk(5'd0, 5'd0, 5'd13, EXE_PIPE_INVALID, 1'b1, 8'h40);
    drive_id(iv);
    tick();
    id_valid = 1'b0;
    chk("t7_count1", dut.count_q, 1);
    tick();
    chk("t7_popped", dut.count_q, 0);
    chk("t7_no_dispatch", ix_valid, 0);
    chk("t7_sb_unchanged", dut.sb_q, 32'h0000_1800);
    tick();
    chk("t7_still_none", ix_valid, 0);

    // Overflow: fifth push while full is dropped; pop+push while full is taken.
    exe_ready = 4'h0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) ovf[k] = mk(5'd0, 5'd0, 5'd0, EXE_PIPE_ALU, 1'b0, 8'(8'h50 + k));
      drive_id(mk(5'd0, 5'd0, 5'd0, EXE_PIPE_ALU, 1'b0, 8'(8'h50 + k)));
      tick();
      chk("t8_count", dut.count_q, (k < 4) ? k + 1 : 4);
      chk("t8_almost_full", ix_almost_full, (k >= 1) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) exp_push(ovf[k], 32'h0, 32'h0);
    ov6 = mk(5'd0, 5'd0, 5'd0, EXE_PIPE_ALU, 1'b0, 8'h56);
    exp_push(ov6, 32'h0, 32'h0);
    exe_ready = 4'hF;
    drive_id(ov6);
    tick();
    id_valid = 1'b0;
    chk("t8_full_push_pop", dut.count_q, 4);
    chk("t8_drain_first", ix_valid, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t8_drain", ix_valid, 1);
    end
    tick();
    chk("t8_drained", ix_valid, 0);
    chk("t8_empty", dut.count_q, 0);

    // Reset mid-operation discards queued work and pending state.
    exe_ready = 4'h0;
    for (int k = 0; k < 2; k++) begin
      drive_id(mk(5'd0, 5'd0, 5'd0, EXE_PIPE_ALU, 1'b0, 8'(8'h60 + k)));
      tick();
    end
    id_valid = 1'b0;
    exe_ready = 4'hF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t9_count", dut.count_q, 0);
    chk("t9_sb", dut.sb_q, 0);
    chk("t9_ix_valid", ix_valid, 0);
    chk("t9_af", ix_almost_full, 0);
    tick(); tick();
    chk("t9_no_dispatch", ix_valid, 0);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_issue.md
INSTRUCTION_ISSUE -- requirements
Module: instruction_issue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, meaning instruction-queue entries; must be a power of two and at least 4.
REQ-002 SHALL have parameter AF_SLACK, default 2, meaning queue slots reserved for instructions already in flight through IFD/ID.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wb_do_branch  input  1  redirect/flush from WB.
REQ-006 SHALL have port id_valid  input  1  decoded instruction present.
REQ-007 SHALL have port id_ix_inf  input  id_ix_inf_t  decoded fields (a1, a2, rd, exe_pipe, register_write, controls).
REQ-008 SHALL have port wb_valid  input  1  register writeback strobe.
REQ-009 SHALL have port wb_rd  input  5  writeback destination.
REQ-010 SHALL have port wb_result  input  32  writeback data.
REQ-011 SHALL have port exe_ready  input  exe_pipe_e width  per-pipe ready (ALU/MUL/DIV/LSU bit positions).
REQ-012 SHALL have port ix_valid  output  1  dispatch strobe, one-cycle pulse per instruction.
REQ-013 SHALL have port ix_inf  output  id_ix_inf_t  dispatched instruction fields, unchanged.
REQ-014 SHALL have port ix_a1_data  output  32  rs1 value.
REQ-015 SHALL have port ix_a2_data  output  32  rs2 value.
REQ-016 SHALL have port ix_almost_full  output  1  stall request to fetch.

Function
REQ-017 SHALL hold a FIFO of IQ_DEPTH entries; on id_valid the entry is pushed at the clock edge, and push is ignored while wb_do_branch is high.
REQ-018 SHALL drive ix_almost_full = (count >= IQ_DEPTH-AF_SLACK), from registered count only.
REQ-019 SHALL, on push while full with no same-cycle pop, drop the entry and fire a simulation assertion; on push and pop in the same cycle while full, it SHALL accept the push.
REQ-020 SHALL hold a 32x32 register file, with x0 reading as 0 and writes to x0 ignored; a write occurs when wb_valid is high.
REQ-021 SHALL hold a 32-bit scoreboard of pending writes, with bit 0 held at 0.
REQ-022 Head SHALL issue when: queue non-empty, no flush, (exe_ready & head.exe_pipe) != 0, a1/a2 not pending (RAW), and rd not pending when register_write=1 (WAW).
REQ-023 Pending check SHALL treat a register as clear when wb_valid && wb_rd matches in the same cycle (bypass); operand data then comes from wb_result, not the array.
REQ-024 On issue SHALL pop head, register ix_valid=1, ix_inf, and operand data next cycle; scoreboard[rd] SHALL be set if register_write.
REQ-025 Same-cycle WB clear and issue set of the same rd SHALL leave the bit set (set wins).
REQ-026 Head with exe_pipe == EXE_PIPE_INVALID SHALL be popped without dispatch (ix_valid stays 0), one entry per cycle.
REQ-027 Latency: push at edge N -> earliest ix_valid high in the cycle after edge N+1; throughput is 1 instruction/cycle.
REQ-028 A stalled head SHALL block younger entries (in-order issue, no bypassing of the head).
REQ-029 On wb_do_branch SHALL empty the queue, clear the scoreboard, and force ix_valid=0 next cycle; the WB register write in that cycle SHALL still occur.

Reset
REQ-030 On rst SHALL set count/pointers=0, scoreboard=0, ix_valid=0, ix_almost_full=0; register file contents and ix_inf/data SHALL NOT be reset.
REQ-031 rst mid-operation SHALL discard queued and dispatching instructions identically to the power-on state.

Verification
REQ-032 Verification: ALU addi x1 (pipe ready, nothing pending) pushed at edge 0 -> ix_valid pulse after edge 1, and scoreboard[1]=1.
REQ-033 Verification: add x3,x1,x2 following x1 pending; WB x1=0x1234 three cycles later -> dispatch in the WB cycle+1 with ix_a1_data=0x1234 (bypass).
REQ-034 Verification: 5 pushes with exe_ready=0 and IQ_DEPTH=4 -> ix_almost_full high at count 2, assertion fires on 5th, count stays 4.
REQ-035 Verification: wb_do_branch with 3 queued and x5 pending -> count=0, scoreboard=0, no ix_valid next cycle, and the WB write lands.
REQ-036 Verification: MUL head with MUL not ready and ALU ready, ALU op behind -> neither issues until exe_ready[MUL]=1.
REQ-037 Verification: exe_pipe=INVALID entry -> popped in 1 cycle, with no ix_valid pulse and no scoreboard change.
